// File: rtl/csa_accumulator.sv
// Streaming accumulator that resolves 4:2 compressor sum/carry beats and sums them into a dot product.
// Optional saturation when CSA_ACC_SAT_EN is defined; the default build wraps modulo 2^ACC_W.
module csa_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

  state_t            state;
  logic              s1_valid;
  logic              s1_last;
  logic [IN_W-1:0]   s1_sum;
  logic [IN_W-1:0]   s1_carry;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  logic              accept;
  logic [ACC_W-1:0]  beat;
  logic [ACC_W-1:0]  raw;
  logic [ACC_W-1:0]  res;
  logic              this_ovf;

  assign accept = in_valid & in_ready;

  // ACC_W >= IN_W + 2 guarantees the beat itself cannot overflow.
  always_comb begin
    beat     = {{(ACC_W-IN_W){s1_sum[IN_W-1]}}, s1_sum}
             + {{(ACC_W-IN_W-1){s1_carry[IN_W-1]}}, s1_carry, 1'b0};
    raw      = acc + beat;
    this_ovf = (acc[ACC_W-1] == beat[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef CSA_ACC_SAT_EN
    if (this_ovf)
      res = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      res = raw;
`else
    res = raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum   <= in_sum;
        s1_carry <= in_carry;
        s1_last  <= in_last;
      end
      if (s1_valid) begin
        acc <= res;
        ovf <= ovf | this_ovf;
      end
      case (state)
        ACC: begin
          in_ready <= !(accept && in_last);
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          in_ready <= 1'b0;
          if (s1_valid && s1_last) begin
            out_data  <= res;
            out_ovf   <= ovf | this_ovf;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator at IN_W=16, ACC_W=18.
// Expected overflow result follows CSA_ACC_SAT_EN when the bench is built with it.
module tb_csa_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic [IN_W-1:0]  in_carry;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;

  csa_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_W-1:0] d(input int v);
    d = ACC_W'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a beat and returns one cycle after its handshake edge.
  task automatic send(input int s, input int c, input logic last);
    int n;
    in_valid = 1'b1;
    in_sum   = IN_W'(s);
    in_carry = IN_W'(c);
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready", in_ready, 1);
    step();
  endtask

  task automatic wait_result(input string tag, input logic [ACC_W-1:0] exp, input logic exp_ovf);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy_in_ready"}, in_ready, 0);
      step();
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_ovf"}, out_ovf, exp_ovf);
    check({tag, "_hold_in_ready"}, in_ready, 0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b0;
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Single beat: 5 + 2*3 = 11, visible exactly two cycles after handshake
    send(5, 3, 1'b1);
    in_valid = 1'b0;
    check("single_t1_in_ready", in_ready, 0);
    check("single_t1_out_valid", out_valid, 0);
    step();
    check("single_t2_out_valid", out_valid, 1);
    check("single_data", out_data, d(11));
    check("single_ovf", out_ovf, 0);
    release_out("single");

    // Four back-to-back beats of -2 + 2*1 = 0
    send(-2, 1, 1'b0);
    send(-2, 1, 1'b0);
    send(-2, 1, 1'b0);
    send(-2, 1, 1'b1);
    in_valid = 1'b0;
    wait_result("four", d(0), 1'b0);
    release_out("four");

    // Mixed signs: 80 + (-1) + (-11) = 68, then backpressure with a beat offered
    send(100, -10, 1'b0);
    send(-1, 0, 1'b0);
    send(3, -7, 1'b1);
    in_valid = 1'b0;
    wait_result("bp", d(68), 1'b0);
    in_valid = 1'b1; in_sum = 16'd9; in_carry = 16'd0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_data_stable", out_data, d(68));
    end
    in_valid = 1'b0;
    release_out("bp");

    // Ignored beat must not leak: -100 + 2*(-50) = -200
    send(-100, -50, 1'b1);
    in_valid = 1'b0;
    wait_result("neg", d(-200), 1'b0);
    release_out("neg");

    // Two beats of 98301 each overflow an 18-bit signed accumulator
    send(32767, 32767, 1'b0);
    send(32767, 32767, 1'b1);
    in_valid = 1'b0;
`ifdef CSA_ACC_SAT_EN
    wait_result("ovf", d(131071), 1'b1);
`else
    wait_result("ovf", d(196602), 1'b1);
`endif
    release_out("ovf");

    // Next dot product starts clean
    send(1, 1, 1'b1);
    in_valid = 1'b0;
    wait_result("after_ovf", d(3), 1'b0);
    release_out("after_ovf");

    // Reset mid-accumulation discards the partial sum
    send(10, 10, 1'b0);
    send(20, 0, 1'b0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    step();
    check("midrst_in_ready_back", in_ready, 1);
    send(7, 0, 1'b1);
    in_valid = 1'b0;
    wait_result("midrst", d(7), 1'b0);
    release_out("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
